mem_port_arbiter: RTL and testbench

- Parametrised N-core arbiter that funnels independent core memory requests onto one shared backing-memory port.
- Sits between per-core cache miss paths and the shared data memory.
- Generalises the fixed four-core, always-ready memory hookup to:
  - N cores,
  - configurable widths,
  - round-robin fairness,
  - a real request/acknowledge handshake with arbitrary memory latency,
  - an optional watchdog timeout.

---
 rtl/mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Round-robin arbiter that funnels N_CORES independent memory requests onto
// one shared memory port. It uses a req/ack handshake with the memory, so the
// memory may take any number of cycles to respond.
//
// Each transaction passes through three states: IDLE -> ISSUE -> RESP.
//   IDLE  : choose the next requesting core, latch its command, raise mem_req.
//   ISSUE : hold the command until mem_ack arrives, or until the watchdog fires.
//   RESP  : one cycle; core_done/core_err are registered at the end of it.
//
// Parameters:
//   N_CORES  number of requesting cores (2..16)
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  ISSUE cycles without an ack before the transaction is aborted
//            (0 disables the watchdog)
//   CNT_W    width of the per-core grant counters
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   core_req/we     per-core request (held until core_done) and write flag
//   core_addr/wdata per-core command, core i at [i*W +: W]
//   core_rdata      read data, broadcast, valid with core_done
//   core_done       one-hot, one-cycle completion pulse
//   core_err        high with core_done when the transaction timed out
//   grant, busy     one-hot owner of the transaction in flight / in-flight flag
//   mem_*           shared memory port (mem_req is held until mem_ack)
//   stat_grants     per-core saturating grant counters
//
// Optional feature: define ARB_STATS_EN to build the grant counters.
// Without it, stat_grants is tied to zero.
module mem_port_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [N_CORES-1:0]          core_done,
    output logic                        core_err,
    output logic [N_CORES-1:0]          grant,
    output logic                        busy,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [N_CORES*CNT_W-1:0]    stat_grants
);

    localparam int IDX_W = $clog2(N_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_CORES-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                err_q, err_d;
    logic [N_CORES-1:0]  done_q, done_d;
    logic                core_err_q, core_err_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                timeout_hit;

    // Round-robin pick. The scan starts one past the last owner and wraps,
    // so the core that was served most recently has the lowest priority.
    always_comb begin
        int cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int j = 1; j <= N_CORES; j++) begin
            cand = (int'(last_grant_q) + j) % N_CORES;
            if (!pick_valid && core_req[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Watchdog: counts ISSUE cycles that end without an ack. It fires on the
    // TIMEOUT-th such cycle, so mem_req stays high for exactly TIMEOUT cycles.
    // If the ack and the timeout land in the same cycle, the ack wins.
    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int WD_W = $clog2(TIMEOUT + 1);
            logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

            assign timeout_hit = (state_q == ISSUE) && !mem_ack &&
                                 (wd_cnt_q == WD_W'(TIMEOUT - 1));

            always_comb begin
                wd_cnt_d = '0;
                if (state_q == ISSUE && !mem_ack && !timeout_hit) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wd_cnt_q <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                end
            end
        end else begin : g_no_wd
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Next-state logic and register updates for the three-state FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        done_d       = '0;
        core_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    mem_req_d         = 1'b1;
                    mem_we_d          = core_we[pick_idx];
                    mem_addr_d        = core_addr[pick_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d       = core_wdata[pick_idx*DATA_W +: DATA_W];
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    // A write leaves the last read data visible.
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // grant_q is one-hot on the owner, so it doubles as the done mask.
                done_d       = grant_q;
                core_err_d   = err_q;
                last_grant_d = owner_q;
                grant_d      = '0;
                busy_d       = 1'b0;
                mem_req_d    = 1'b0;
                err_d        = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            owner_q      <= '0;
            // Start one below core 0 so the first grant goes to core 0.
            last_grant_q <= IDX_W'(N_CORES - 1);
            err_q        <= 1'b0;
            done_q       <= '0;
            core_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            done_q       <= done_d;
            core_err_q   <= core_err_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_done  = done_q;
    assign core_err   = core_err_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef ARB_STATS_EN
    // Per-core grant counters. They advance when the owner reaches RESP,
    // which includes timed-out transactions, and they saturate at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (state_q == RESP && owner_q == IDX_W'(gi) && !(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stat_grants[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: 4 cores, 8-bit address/data, TIMEOUT=8,
// CNT_W=2. Expected completions go into sb_q. Expected memory commands go
// into mem_q. The monitor and the memory model pop and compare them
// independently of the stimulus. The memory answers reads with addr ^ 8'h66.
module tb_mem_port_arbiter;

    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 2;

    logic               clk;
    logic               rst;
    logic [NC-1:0]      core_req;
    logic [NC-1:0]      core_we;
    logic [NC*AW-1:0]   core_addr;
    logic [NC*DW-1:0]   core_wdata;
    logic [DW-1:0]      core_rdata;
    logic [NC-1:0]      core_done;
    logic               core_err;
    logic [NC-1:0]      grant;
    logic               busy;
    logic               mem_req;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               mem_ack;
    logic [NC*CW-1:0]   stat_grants;

    mem_port_arbiter #(
        .N_CORES (NC),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_done   (core_done),
        .core_err    (core_err),
        .grant       (grant),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stat_grants (stat_grants)
    );

    typedef struct packed {
        logic [3:0] done;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [16:0] mem_q[$];   // {we, addr, wdata}
    int          tests = 0;
    int          fails = 0;
    int          ack_lat = 0; // ISSUE cycles before ack; large = never

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic set_core(input int i, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        core_we[i]           = we;
        core_addr[i*AW +: AW] = addr;
        core_wdata[i*DW +: DW] = wd;
    endtask

    task automatic expect_txn(input logic [3:0] done, input logic err, input logic [7:0] rd,
                              input logic we, input logic [7:0] addr, input logic [7:0] wd);
        exp_t e;
        e.done  = done;
        e.err   = err;
        e.rdata = rd;
        sb_q.push_back(e);
        mem_q.push_back({we, addr, wd});
    endtask

    // Waits for the next core_done and counts the negedges spent waiting,
    // plus how many of them saw mem_req high.
    task automatic wait_done(output int n, output int hi);
        n  = 0;
        hi = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (mem_req) hi++;
            if (core_done != '0) break;
            if (n >= 40) begin
                tests++;
                fails++;
                $display("FAIL done_wait: no core_done after %0d cycles, required one", n);
                break;
            end
        end
    endtask

    // Memory model: checks each new command and acks after ack_lat ISSUE cycles.
    initial begin
        int  c;
        bit  seen;
        c         = 0;
        seen      = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    c    = 0;
                    if (mem_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mem_cmd: unexpected request addr=%h, required none", mem_addr);
                    end else begin
                        check("mem_cmd", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, mem_q.pop_front()});
                    end
                end else begin
                    c++;
                end
                if (c == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ 8'h66;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_done != '0) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: core_done=%b, required no completion", core_done);
                end else begin
                    e = sb_q.pop_front();
                    check("done",  {28'd0, core_done}, {28'd0, e.done});
                    check("err",   {31'd0, core_err},  {31'd0, e.err});
                    check("rdata", {24'd0, core_rdata}, {24'd0, e.rdata});
                    check("grant_cleared", {28'd0, grant}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hi;
        logic [7:0] exp_stat;

        rst        = 1'b0;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {24'd0, core_done, grant}, 32'd0);
        check("rst_flags", {28'd0, busy, mem_req, mem_we, core_err}, 32'd0);
        check("rst_data", {8'd0, mem_addr, mem_wdata, core_rdata}, 32'd0);
        check("rst_stats", {24'd0, stat_grants}, 32'd0);

        for (int i = 0; i < NC; i++) set_core(i, 1'b0, 8'(32'h20 + i), 8'(32'h90 + i));
        rst = 1'b1;

        // All cores request continuously with a zero-wait memory:
        // order 0,1,2,3,0 and 3 cycles per transaction.
        ack_lat = 0;
        expect_txn(4'b0001, 1'b0, 8'h46, 1'b0, 8'h20, 8'h90);
        expect_txn(4'b0010, 1'b0, 8'h47, 1'b0, 8'h21, 8'h91);
        expect_txn(4'b0100, 1'b0, 8'h44, 1'b0, 8'h22, 8'h92);
        expect_txn(4'b1000, 1'b0, 8'h45, 1'b0, 8'h23, 8'h93);
        expect_txn(4'b0001, 1'b0, 8'h46, 1'b0, 8'h20, 8'h90);
        core_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_done(n, hi);
            check("rr_cycles", n, 32'd3);
        end
        core_req = '0;

        // Single read by core 2; memory acks 2 cycles after mem_req.
        @(negedge clk);
        ack_lat = 1;
        set_core(2, 1'b0, 8'h3A, 8'h92);
        expect_txn(4'b0100, 1'b0, 8'h5C, 1'b0, 8'h3A, 8'h92);
        core_req = 4'b0100;
        wait_done(n, hi);
        core_req = '0;
        check("read_cycles", n, 32'd4);
        check("read_req_hi", hi, 32'd2);

        // Write by core 1 acked in the first ISSUE cycle; rdata unchanged.
        @(negedge clk);
        ack_lat = 0;
        set_core(1, 1'b1, 8'h10, 8'hA5);
        expect_txn(4'b0010, 1'b0, 8'h5C, 1'b1, 8'h10, 8'hA5);
        core_req = 4'b0010;
        wait_done(n, hi);
        core_req = '0;
        check("write_cycles", n, 32'd3);

        // Memory never acks: the watchdog aborts after 8 cycles with core_err.
        @(negedge clk);
        ack_lat = 1000;
        set_core(3, 1'b0, 8'h77, 8'h93);
        expect_txn(4'b1000, 1'b1, 8'h5C, 1'b0, 8'h77, 8'h93);
        core_req = 4'b1000;
        wait_done(n, hi);
        core_req = '0;
        check("to_req_hi", hi, 32'd8);
        check("to_cycles", n, 32'd10);

        // The next request arbitrates normally.
        @(negedge clk);
        ack_lat = 1;
        set_core(0, 1'b0, 8'h05, 8'h90);
        expect_txn(4'b0001, 1'b0, 8'h63, 1'b0, 8'h05, 8'h90);
        core_req = 4'b0001;
        wait_done(n, hi);
        core_req = '0;
        check("after_to_cycles", n, 32'd4);

        // Reset during ISSUE: outputs drop at once and no completion is issued.
        @(negedge clk);
        ack_lat = 1000;
        set_core(0, 1'b0, 8'h20, 8'h90);
        set_core(1, 1'b0, 8'h21, 8'h91);
        set_core(2, 1'b0, 8'h22, 8'h92);
        set_core(3, 1'b0, 8'h23, 8'h93);
        mem_q.push_back({1'b0, 8'h21, 8'h91});
        core_req = 4'b0010;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {28'd0, grant, busy, mem_req}, {28'd0, 4'b0010, 1'b1, 1'b1} >> 0);
        rst = 1'b0;
        #1;
        check("async_rst", {24'd0, grant, busy, mem_req}, 32'd0);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            check("rst_no_done", {28'd0, core_done}, 32'd0);
        end
        ack_lat = 0;
        expect_txn(4'b0001, 1'b0, 8'h46, 1'b0, 8'h20, 8'h90);
        core_req = 4'b1111;
        rst = 1'b1;
        wait_done(n, hi);
        core_req = '0;
        check("post_rst_cycles", n, 32'd3);

        // Fresh reset, then core 2 served 5 times: counter saturates at 3.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_core(2, 1'b0, 8'h3A, 8'h92);
        for (int t = 0; t < 5; t++) begin
            expect_txn(4'b0100, 1'b0, 8'h5C, 1'b0, 8'h3A, 8'h92);
            core_req = 4'b0100;
            wait_done(n, hi);
            core_req = '0;
            if (t == 1) begin
`ifdef ARB_STATS_EN
                exp_stat = 8'h20;
`else
                exp_stat = 8'h00;
`endif
                check("stats_two", {24'd0, stat_grants}, {24'd0, exp_stat});
            end
        end
`ifdef ARB_STATS_EN
        exp_stat = 8'h30;
`else
        exp_stat = 8'h00;
`endif
        check("stats_sat", {24'd0, stat_grants}, {24'd0, exp_stat});

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
